alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Arbitrates two requesters onto the single shared 8-bit ALU (3-bit opcode; flags zero, negative, carry, overflow) and sequences each operation.
- Each operation runs as capture, then execute, then respond.
- The block drives the ALU's a, b and s inputs from registers and samples its result and flags.
- It returns one tagged response per accepted request over a valid/ready channel.
- Sits between the two operand sources (e.g. fetch/decode and a DMA-style helper) and the ALU instance.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU data width.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  bit i = requester i has a request.
- req_ready  output  2  bit i = request i accepted this cycle (one-hot or zero).
- req_a  input  2*WIDTH  operand a; {req1, req0}.
- req_b  input  2*WIDTH  operand b; {req1, req0}.
- req_op  input  6  opcode; {op1, op0}, 3 bits each.
- alu_a  output  WIDTH  registered operand a to the ALU.
- alu_b  output  WIDTH  registered operand b to the ALU.
- alu_s  output  3  registered opcode to the ALU.
- alu_out  input  WIDTH  ALU result.
- alu_z, alu_n, alu_c, alu_v  input  1 each  ALU flags.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester index of the response.
- rsp_data  output  WIDTH  latched result.
- rsp_z, rsp_n, rsp_c, rsp_v  output  1 each  latched flags.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. All outputs are registered except req_ready, which is combinational from state, req_valid and the pointer.
- Reset (async, rst_n=0):
  - state=IDLE; last-grant pointer=1, so requester 0 wins first.
  - alu_a, alu_b, alu_s, rsp_data=0.
  - all rsp flags=0; rsp_valid=0; rsp_id=0; busy=0.
  - Any in-flight or pending response is discarded; nothing is replayed after reset.
- IDLE, no req_valid: req_ready=0; stay in IDLE.
- IDLE, one req_valid bit set: grant that requester.
- IDLE, both bits set: grant the requester that is not the last-grant pointer (round robin).
- Grant, in the same cycle:
  - req_ready[g]=1.
  - Capture req_a/req_b/req_op[g] into alu_a/alu_b/alu_s.
  - Record g as the tag; update the pointer to g; go to EXEC.
- EXEC (exactly 1 cycle): the ALU evaluates the held inputs. At the end of the cycle:
  - latch alu_out into rsp_data; latch the four flags into the rsp flags;
  - set rsp_id to the tag; set rsp_valid=1; go to RESP.
- RESP: hold rsp_valid and all rsp_* stable until rsp_ready=1.
  - On that cycle the response completes; next state IDLE; rsp_valid=0 next cycle.
  - rsp_data and the rsp flags retain their values after completion.
- alu_a/alu_b/alu_s hold their values until the next grant; they are not cleared on return to IDLE.
- No request is accepted outside IDLE. A requester keeps req_valid and its operands stable until it sees its req_ready bit; a dropped req_valid is simply not granted.
- Throughput: minimum 3 cycles per operation (grant, EXEC, RESP with rsp_ready=1). Latency from grant to rsp_valid: 2 rising edges.
- Opcodes are passed to the ALU unmodified; the block does no arithmetic or width conversion. Flags are forwarded exactly as sampled, including the constant-0 c/v.
- req_ready is never asserted for a requester whose req_valid is 0, and never to both requesters at once.

Test Plan:
- Single ADD: req0 a=8'h05, b=8'h03, op=3'b000 -> req_ready=2'b01 in the same cycle; 2 edges later rsp_valid=1, rsp_id=0, rsp_data=8'h08, z=0, n=0, c=0, v=0.
- SUB negative: req1 a=8'h03, b=8'h05, op=3'b001 -> rsp_id=1, rsp_data=8'hFE, n=1, z=0.
- XOR to zero: req0 a=b=8'hA5, op=3'b100 -> rsp_data=8'h00, z=1, n=0.
- Round robin: both held valid from reset, rsp_ready=1 throughout, 4 ops -> grant order 0,1,0,1; each grant 3 cycles apart; busy low only on the grant cycles.
- Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_* stable; req_ready=2'b00 despite req_valid=2'b11; completes on the first rsp_ready=1.
- Reset in EXEC: rst_n pulled low mid-cycle -> immediately rsp_valid=0, busy=0, alu_* and rsp_data=0. After release with both requesters valid, the first grant goes to requester 0.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter that shares one ALU between two
// requesters. Each accepted request is captured into the ALU input
// registers, evaluated for one cycle, and returned as a tagged response.
module alu_share_arb #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    // Requester side: {req1, req0} packing on every bus
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [5:0]         req_op,
    // Shared ALU
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_s,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_z,
    input  logic               alu_n,
    input  logic               alu_c,
    input  logic               alu_v,
    // Response channel
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_z,
    output logic               rsp_n,
    output logic               rsp_c,
    output logic               rsp_v,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q;
    // Last-granted requester. It doubles as the response tag: it is
    // written with the granted index on every grant and not touched again
    // until the next grant.
    logic             ptr_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_s_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_z_q;
    logic             rsp_n_q;
    logic             rsp_c_q;
    logic             rsp_v_q;
    logic             busy_q;

    logic             grant_vld;
    logic             grant_idx;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;
    logic [2:0]       grant_op;

    // Grant decision: only in IDLE, round robin when both requesters are valid.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (state_q == IDLE) begin
            case (req_valid)
                2'b01:   begin grant_vld = 1'b1; grant_idx = 1'b0;   end
                2'b10:   begin grant_vld = 1'b1; grant_idx = 1'b1;   end
                2'b11:   begin grant_vld = 1'b1; grant_idx = ~ptr_q; end
                default: begin grant_vld = 1'b0; grant_idx = 1'b0;   end
            endcase
        end
        req_ready = grant_vld ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
        grant_a   = grant_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        grant_b   = grant_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
        grant_op  = grant_idx ? req_op[5:3]            : req_op[2:0];
    end

    // Sequencer: capture on grant, sample the ALU in EXEC, hold the response in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b1;  // requester 0 wins the first contest
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_z_q     <= 1'b0;
            rsp_n_q     <= 1'b0;
            rsp_c_q     <= 1'b0;
            rsp_v_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        alu_a_q <= grant_a;
                        alu_b_q <= grant_b;
                        alu_s_q <= grant_op;
                        ptr_q   <= grant_idx;
                        state_q <= EXEC;
                        busy_q  <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_out;
                    rsp_z_q     <= alu_z;
                    rsp_n_q     <= alu_n;
                    rsp_c_q     <= alu_c;
                    rsp_v_q     <= alu_v;
                    rsp_id_q    <= ptr_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    // Data and flags are left as they are after the handshake.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_n     = rsp_n_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_v     = rsp_v_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small behavioural ALU attached.
// Inputs are driven and outputs observed on the falling clock edge.
module tb_alu_share_arb;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [5:0]         req_op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [2:0]         alu_s;
    logic [WIDTH-1:0]   alu_out;
    logic               alu_z;
    logic               alu_n;
    logic               alu_c;
    logic               alu_v;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_z;
    logic               rsp_n;
    logic               rsp_c;
    logic               rsp_v;
    logic               busy;

    int passed;
    int total;

    alu_share_arb #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_out   (alu_out),
        .alu_z     (alu_z),
        .alu_n     (alu_n),
        .alu_c     (alu_c),
        .alu_v     (alu_v),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_z     (rsp_z),
        .rsp_n     (rsp_n),
        .rsp_c     (rsp_c),
        .rsp_v     (rsp_v),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU: the carry and overflow flags are tied to 0.
    always_comb begin
        case (alu_s)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b010:  alu_out = alu_a & alu_b;
            3'b011:  alu_out = alu_a | alu_b;
            3'b100:  alu_out = alu_a ^ alu_b;
            default: alu_out = alu_a;
        endcase
        alu_z = (alu_out == '0);
        alu_n = alu_out[WIDTH-1];
        alu_c = 1'b0;
        alu_v = 1'b0;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to the next falling edge, one rising edge later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;

        // ---- Reset state
        step();
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_alu_a",     alu_a,     8'h00);
        check("rst_rsp_data",  rsp_data,  8'h00);
        check("rst_req_ready", req_ready, 2'b00);
        step();
        rst_n = 1'b1;

        // ---- Single ADD from requester 0
        step();
        req_valid = 2'b01;
        req_a     = {8'h00, 8'h05};
        req_b     = {8'h00, 8'h03};
        req_op    = {3'b000, 3'b000};
        #1;
        check("add_req_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        #1;
        check("add_alu_a",     alu_a,     8'h05);
        check("add_alu_b",     alu_b,     8'h03);
        check("add_busy_exec", busy,      1'b1);
        check("add_not_valid", rsp_valid, 1'b0);
        step();
        check("add_rsp_valid", rsp_valid, 1'b1);
        check("add_rsp_id",    rsp_id,    1'b0);
        check("add_rsp_data",  rsp_data,  8'h08);
        check("add_flags",     {rsp_z, rsp_n, rsp_c, rsp_v}, 4'b0000);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("add_done_valid", rsp_valid, 1'b0);
        check("add_done_busy",  busy,      1'b0);
        check("add_data_kept",  rsp_data,  8'h08);
        check("add_alu_a_kept", alu_a,     8'h05);

        // ---- SUB negative from requester 1, then backpressure in RESP
        req_valid = 2'b10;
        req_a     = {8'h03, 8'h00};
        req_b     = {8'h05, 8'h00};
        req_op    = {3'b001, 3'b000};
        #1;
        check("sub_req_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        step();
        req_valid = 2'b11;
        check("sub_rsp_valid", rsp_valid, 1'b1);
        check("sub_rsp_id",    rsp_id,    1'b1);
        check("sub_rsp_data",  rsp_data,  8'hFE);
        check("sub_flags",     {rsp_z, rsp_n, rsp_c, rsp_v}, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_data",  {rsp_id, rsp_data}, {1'b1, 8'hFE});
            check("bp_flags",     {rsp_z, rsp_n, rsp_c, rsp_v}, 4'b0100);
            check("bp_req_ready", req_ready, 2'b00);
            check("bp_busy",      busy,      1'b1);
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        step();
        rsp_ready = 1'b0;
        check("bp_done_valid", rsp_valid, 1'b0);
        check("bp_done_busy",  busy,      1'b0);
        check("bp_data_kept",  rsp_data,  8'hFE);

        // ---- XOR to zero from requester 0
        req_valid = 2'b01;
        req_a     = {8'h00, 8'hA5};
        req_b     = {8'h00, 8'hA5};
        req_op    = {3'b000, 3'b100};
        #1;
        check("xor_req_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("xor_alu_s", alu_s, 3'b100);
        step();
        check("xor_rsp_valid", rsp_valid, 1'b1);
        check("xor_rsp_id",    rsp_id,    1'b0);
        check("xor_rsp_data",  rsp_data,  8'h00);
        check("xor_flags",     {rsp_z, rsp_n, rsp_c, rsp_v}, 4'b1000);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("xor_done_valid", rsp_valid, 1'b0);

        // ---- Round robin: both valid from reset, rsp_ready always 1
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = {8'h10, 8'h01};
        req_b     = {8'h01, 8'h01};
        req_op    = {3'b000, 3'b000};
        rsp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rr_grant",      req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_busy_grant", busy,      1'b0);
            step();
            check("rr_busy_exec",  busy,      1'b1);
            check("rr_ready_exec", req_ready, 2'b00);
            step();
            check("rr_rsp_valid",  rsp_valid, 1'b1);
            check("rr_rsp_id",     rsp_id,    (i % 2 == 0) ? 1'b0 : 1'b1);
            check("rr_rsp_data",   rsp_data,  (i % 2 == 0) ? 8'h02 : 8'h11);
            check("rr_busy_resp",  busy,      1'b1);
            step();
        end

        // ---- Reset in EXEC, then requester 0 must win again
        check("rst_exec_grant", req_ready, 2'b01);
        step();
        check("rst_exec_busy",  busy,  1'b1);
        check("rst_exec_alu_a", alu_a, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstx_rsp_valid", rsp_valid, 1'b0);
        check("rstx_busy",      busy,      1'b0);
        check("rstx_alu",       {alu_a, alu_b}, 16'h0000);
        check("rstx_alu_s",     alu_s,     3'b000);
        check("rstx_rsp_data",  rsp_data,  8'h00);
        check("rstx_rsp_id",    rsp_id,    1'b0);
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", req_ready, 2'b01);
        step();
        check("post_rst_alu_a", alu_a, 8'h01);
        check("post_rst_busy",  busy,  1'b1);
        check("post_rst_novld", rsp_valid, 1'b0);
        step();
        check("post_rst_rsp_valid", rsp_valid, 1'b1);
        check("post_rst_rsp_id",    rsp_id,    1'b0);
        check("post_rst_rsp_data",  rsp_data,  8'h02);
        req_valid = 2'b00;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
